// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: decoded operands in, stall/forward controls out.
interface hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int DEPTH = 3
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic          id_kill;
    logic          ex_kill;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd;
    logic          id_rd_we;
    logic [SW-1:0] id_lat;
    logic          stall;
    logic          pc_en;
    logic          if_id_en;
    logic          id_ex_clear;
    logic [SW-1:0] rs1_fwd;
    logic [SW-1:0] rs2_fwd;

    modport master (
        output id_valid, id_kill, ex_kill,
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_we, id_lat,
        input  stall, pc_en, if_id_en, id_ex_clear,
        input  rs1_fwd, rs2_fwd
    );

    modport slave (
        input  id_valid, id_kill, ex_kill,
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_we, id_lat,
        output stall, pc_en, if_id_en, id_ex_clear,
        output rs1_fwd, rs2_fwd
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard producing stall and forwarding selects for ID.
// Optional HAZARD_STALL_CNT_EN adds saturating stall/kill event counters.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int DEPTH = 3,
    parameter int AW    = $clog2(NREG),
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] kill_cnt,
`endif
    hazard_scoreboard_if.slave hz
);
    localparam logic [SW-1:0] ONE  = SW'(1);
    localparam logic [SW-1:0] DMAX = SW'(DEPTH);

    logic [NREG-1:0] pend;
    logic [SW-1:0]   age [NREG];
    logic [SW-1:0]   lat [NREG];

    logic          hit1, hit2, rdy1, rdy2;
    logic          stall, issue;
    logic [SW-1:0] lat_in;

    always_comb begin
        hit1 = hz.id_valid & hz.id_rs1_used & (hz.id_rs1 != '0) & pend[hz.id_rs1];
        hit2 = hz.id_valid & hz.id_rs2_used & (hz.id_rs2 != '0) & pend[hz.id_rs2];
        rdy1 = age[hz.id_rs1] >= lat[hz.id_rs1];
        rdy2 = age[hz.id_rs2] >= lat[hz.id_rs2];
        stall = ~hz.id_kill & ((hit1 & ~rdy1) | (hit2 & ~rdy2));
        issue = hz.id_valid & ~hz.id_kill & ~stall & hz.id_rd_we & (hz.id_rd != '0);
        lat_in = hz.id_lat;
        if (lat_in == '0) lat_in = ONE;
        else if (lat_in > DMAX) lat_in = DMAX;
    end

    assign hz.stall       = stall;
    assign hz.pc_en       = ~stall;
    assign hz.if_id_en    = ~stall;
    assign hz.id_ex_clear = stall | hz.id_kill;
    assign hz.rs1_fwd     = (hit1 & rdy1) ? age[hz.id_rs1] : '0;
    assign hz.rs2_fwd     = (hit2 & rdy2) ? age[hz.id_rs2] : '0;

    // A new issue to rd overrides retirement or EX kill of the older entry.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst || r == 0) begin
                pend[r] <= 1'b0;
                age[r]  <= '0;
                lat[r]  <= '0;
            end else if (issue && hz.id_rd == AW'(r)) begin
                pend[r] <= 1'b1;
                age[r]  <= ONE;
                lat[r]  <= lat_in;
            end else if (pend[r]) begin
                if (age[r] == DMAX || (hz.ex_kill && age[r] == ONE)) begin
                    pend[r] <= 1'b0;
                    age[r]  <= '0;
                    lat[r]  <= '0;
                end else begin
                    age[r] <= age[r] + ONE;
                end
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if ((hz.id_kill || hz.ex_kill) && kill_cnt != '1)
                kill_cnt <= kill_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a timestamp-based issue model.
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int D    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .DEPTH(D)) bus ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt, kill_cnt;
    longint ms_stall, ms_kill;
`endif

    hazard_scoreboard #(.NREG(NREG), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
        .kill_cnt(kill_cnt),
`endif
        .hz(bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    bit mv [NREG];
    int mc [NREG];
    int ml [NREG];

    logic       s_stall, s_clr;
    logic [1:0] s_f1, s_f2;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: an instruction issued in cycle c has age n-c in cycle n.
    function automatic int age_of(int r);
        return cyc_n - mc[r];
    endfunction

    function automatic bit pend_m(int r);
        return r != 0 && mv[r] && age_of(r) >= 1 && age_of(r) <= D;
    endfunction

    task automatic drv(bit v, bit k, bit xk, int r1, bit u1,
                       int r2, bit u2, int rd, bit we, int l);
        bus.id_valid    = v;
        bus.id_kill     = k;
        bus.ex_kill     = xk;
        bus.id_rs1      = 5'(r1);
        bus.id_rs1_used = u1;
        bus.id_rs2      = 5'(r2);
        bus.id_rs2_used = u2;
        bus.id_rd       = 5'(rd);
        bus.id_rd_we    = we;
        bus.id_lat      = 2'(l);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        bit h1, h2, r1, r2, est, iss, v, k, xk;
        int ef1, ef2, s1, s2, rd, l;
        @(negedge clk);
        v  = bus.id_valid;
        k  = bus.id_kill;
        xk = bus.ex_kill;
        s1 = int'(bus.id_rs1);
        s2 = int'(bus.id_rs2);
        rd = int'(bus.id_rd);
        l  = int'(bus.id_lat);
        h1 = v && bus.id_rs1_used && pend_m(s1);
        h2 = v && bus.id_rs2_used && pend_m(s2);
        r1 = h1 && age_of(s1) >= ml[s1];
        r2 = h2 && age_of(s2) >= ml[s2];
        est = !k && ((h1 && !r1) || (h2 && !r2));
        ef1 = r1 ? age_of(s1) : 0;
        ef2 = r2 ? age_of(s2) : 0;
        s_stall = bus.stall;
        s_clr   = bus.id_ex_clear;
        s_f1    = bus.rs1_fwd;
        s_f2    = bus.rs2_fwd;
        chk("stall", 32'(s_stall), 32'(est));
        chk("rs1_fwd", 32'(s_f1), 32'(ef1));
        chk("rs2_fwd", 32'(s_f2), 32'(ef2));
        chk("pc_en", 32'(bus.pc_en), 32'(!est));
        chk("if_id_en", 32'(bus.if_id_en), 32'(!est));
        chk("id_ex_clear", 32'(s_clr), 32'(est || k));
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(ms_stall));
        chk("kill_cnt", kill_cnt, 32'(ms_kill));
`endif
        iss = v && !k && !est && bus.id_rd_we && rd != 0;
        @(posedge clk);
        if (rst) begin
            foreach (mv[i]) mv[i] = 0;
`ifdef HAZARD_STALL_CNT_EN
            ms_stall = 0;
            ms_kill  = 0;
`endif
        end else begin
`ifdef HAZARD_STALL_CNT_EN
            if (est && ms_stall < 64'hFFFF_FFFF) ms_stall++;
            if ((k || xk) && ms_kill < 64'hFFFF_FFFF) ms_kill++;
`endif
            if (xk)
                for (int r = 0; r < NREG; r++)
                    if (pend_m(r) && age_of(r) == 1) mv[r] = 0;
            if (iss) begin
                mv[rd] = 1;
                mc[rd] = cyc_n;
                ml[rd] = (l == 0) ? 1 : ((l > D) ? D : l);
            end
        end
        cyc_n++;
        #1;
    endtask

    initial begin
        foreach (mv[i]) begin
            mv[i] = 0;
            mc[i] = 0;
            ml[i] = 0;
        end
`ifdef HAZARD_STALL_CNT_EN
        ms_stall = 0;
        ms_kill  = 0;
`endif
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        step();
        chk("rst_stall", 32'(s_stall), 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_clr_kill", 32'(s_clr), 1);

        drv(1, 0, 0, 0, 0, 0, 0, 5, 1, 1);
        step();
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        step();
        chk("b2b_stall", 32'(s_stall), 0);
        chk("b2b_fwd1", 32'(s_f1), 1);
        step();
        chk("b2b_fwd2", 32'(s_f1), 2);
        step();
        chk("b2b_fwd3", 32'(s_f1), 3);
        step();
        chk("b2b_retired", 32'(s_f1), 0);

        drv(1, 0, 0, 0, 0, 0, 0, 7, 1, 2);
        step();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step();
        chk("lu_stall", 32'(s_stall), 1);
        chk("lu_clear", 32'(s_clr), 1);
        step();
        chk("lu_release", 32'(s_stall), 0);
        chk("lu_fwd2", 32'(s_f2), 2);

        drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 2);
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 1);
        step();
        drv(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        step();
        chk("waw_stall", 32'(s_stall), 0);
        chk("waw_fwd", 32'(s_f1), 1);

        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        chk("x0_fwd", 32'(s_f1), 0);

        drv(1, 0, 0, 0, 0, 0, 0, 5, 1, 3);
        step();
        drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        step();
        chk("unused_stall", 32'(s_stall), 0);
        drv(1, 1, 0, 5, 1, 0, 0, 6, 1, 1);
        step();
        chk("idkill_stall", 32'(s_stall), 0);
        chk("idkill_clear", 32'(s_clr), 1);
        drv(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        step();
        chk("idkill_noentry", 32'(s_f1), 0);

        drv(1, 0, 0, 0, 0, 0, 0, 9, 1, 1);
        step();
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        step();
        chk("exkill_fwd", 32'(s_f1), 0);

        idle();
        repeat (3) step();
        drv(1, 0, 0, 0, 0, 0, 0, 10, 1, 3);
        step();
        drv(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        step();
        chk("mid_stall", 32'(s_stall), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_stall", 32'(s_stall), 0);
        chk("post_rst_fwd", 32'(s_f1), 0);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drv(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 3));
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
